// File: rtl/alu_shift_issue.sv
// Operand-issue stage for the ALU shifter: decodes SLL/SRL/SRA, registers the entry, 2-entry skid buffer.
// Optional: define ALU_SHIFT_ILLEGAL_CHECK_EN to flag shift-immediates with reserved shamt[5] set.
module alu_shift_issue #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [SHW-1:0]  out_n,
  output logic [1:0]      out_op,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_NONE = 2'b11
  } op_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    op_e             op;
    logic [4:0]      rd;
`ifdef ALU_SHIFT_ILLEGAL_CHECK_EN
    logic            illegal;
`endif
  } entry_t;

  entry_t m_q, m_d;   // main entry, drives the ALU
  entry_t s_q, s_d;   // skid entry, catches the beat accepted while M stalls
  entry_t inc;
  logic   in_ready_q, in_ready_d;
  logic   accept, drain;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    inc       = '0;
    inc.valid = 1'b1;
    inc.a     = in_rs1;
    inc.b     = in_use_imm ? in_imm : in_rs2;
    inc.rd    = in_rd;
    case (in_funct3)
      3'b001:  inc.op = OP_SLL;
      3'b101:  inc.op = in_funct7b5 ? OP_SRA : OP_SRL;
      default: inc.op = OP_NONE;
    endcase
`ifdef ALU_SHIFT_ILLEGAL_CHECK_EN
    inc.illegal = in_use_imm && (inc.op != OP_NONE) && in_imm[5];
`endif

    accept = in_valid & in_ready_q;
    drain  = ~m_q.valid | out_ready;
    m_d    = m_q;
    s_d    = s_q;

    if (flush) begin
      m_d.valid = 1'b0;
      s_d.valid = 1'b0;
    end else if (drain) begin
      if (s_q.valid) begin
        m_d       = s_q;
        s_d       = inc;
        s_d.valid = accept;
      end else begin
        m_d       = inc;
        m_d.valid = accept;
      end
    end else if (accept) begin
      s_d = inc;
    end

    // Ready is the registered complement of the next skid state: no out_ready->in_ready path.
    in_ready_d = ~s_d.valid;
  end

  // NOTE: the two entries are plain registers, so they are fully reset to give all-zero outputs in reset.
  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_q.valid;
  assign out_a     = m_q.a;
  assign out_b     = m_q.b;
  assign out_n     = m_q.b[SHW-1:0];
  assign out_op    = m_q.op;
  assign out_rd    = m_q.rd;
`ifdef ALU_SHIFT_ILLEGAL_CHECK_EN
  assign out_illegal = m_q.illegal;
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_shift_issue.sv
// Self-checking bench for alu_shift_issue: queue-based reference model plus directed literal checks.
module tb_alu_shift_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_rs1 = '0, in_rs2 = '0, in_imm = '0;
  logic        in_use_imm = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic        in_funct7b5 = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a, out_b;
  logic [4:0]  out_n;
  logic [1:0]  out_op;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int total = 0;
  int bad   = 0;

  alu_shift_issue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_n(out_n), .out_op(out_op),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  bit   after_reset = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit exp_ready();
    return !after_reset && (exp_q.size() < 2);
  endfunction

  // Expected entry from the current decode-side inputs, straight from the op rules.
  function automatic exp_t make_exp();
    exp_t e;
    e.a  = in_rs1;
    e.b  = in_use_imm ? in_imm : in_rs2;
    e.rd = in_rd;
    if (in_funct3 == 3'd1)      e.op = 2'd0;
    else if (in_funct3 == 3'd5) e.op = in_funct7b5 ? 2'd2 : 2'd1;
    else                        e.op = 2'd3;
`ifdef ALU_SHIFT_ILLEGAL_CHECK_EN
    e.ill = in_use_imm && (e.op != 2'd3) && in_imm[5];
`else
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  task automatic compare();
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready()});
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      check("out_a", out_a, exp_q[0].a);
      check("out_b", out_b, exp_q[0].b);
      check("out_n", {27'd0, out_n}, {27'd0, exp_q[0].b[4:0]});
      check("out_op", {30'd0, out_op}, {30'd0, exp_q[0].op});
      check("out_rd", {27'd0, out_rd}, {27'd0, exp_q[0].rd});
      check("out_illegal", {31'd0, out_illegal}, {31'd0, exp_q[0].ill});
    end
  endtask

  // Advance the model across one rising edge, then compare on the falling edge.
  task automatic cycle();
    bit acc, drn;
    exp_t e;
    acc = in_valid && exp_ready();
    drn = (exp_q.size() == 0) || out_ready;
    e   = make_exp();
    if (flush) exp_q.delete();
    else begin
      if (drn && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
    end
    @(posedge clk);
    after_reset = 1'b0;
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input bit v, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input bit ui, input logic [2:0] f3,
                       input bit f7, input logic [4:0] rd, input bit ordy, input bit fl);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_use_imm = ui;
    in_funct3 = f3; in_funct7b5 = f7; in_rd = rd; out_ready = ordy; flush = fl;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    compare();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle();
    check("rst_release_ready", {31'd0, in_ready}, 32'd1);
    check("rst_release_valid", {31'd0, out_valid}, 32'd0);

    // SRA issue
    drive(1, 32'h8000_0010, 32'h0000_0024, 32'h0, 0, 3'b101, 1, 5'd7, 1, 0);
    cycle();
    check("sra_valid", {31'd0, out_valid}, 32'd1);
    check("sra_a", out_a, 32'h8000_0010);
    check("sra_n", {27'd0, out_n}, 32'd4);
    check("sra_op", {30'd0, out_op}, 32'd2);
    check("sra_rd", {27'd0, out_rd}, 32'd7);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle();

    // Back-pressure: three back-to-back, ALU stalled
    drive(1, 32'h11, 32'h1, 0, 0, 3'b001, 0, 5'd1, 0, 0); cycle();
    check("bp_ready_c1", {31'd0, in_ready}, 32'd1);
    drive(1, 32'h22, 32'h2, 0, 0, 3'b101, 0, 5'd2, 0, 0); cycle();
    check("bp_ready_c2", {31'd0, in_ready}, 32'd0);
    drive(1, 32'h33, 32'h3, 0, 0, 3'b000, 0, 5'd3, 0, 0); cycle();
    check("bp_hold_rd", {27'd0, out_rd}, 32'd1);
    check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; cycle();
    check("bp_out2_rd", {27'd0, out_rd}, 32'd2);
    cycle();
    check("bp_out3_rd", {27'd0, out_rd}, 32'd3);
    in_valid = 1'b0; cycle();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush collision with M and S full
    drive(1, 32'hA, 0, 0, 0, 3'b001, 0, 5'd10, 0, 0); cycle();
    drive(1, 32'hB, 0, 0, 0, 3'b001, 0, 5'd11, 0, 0); cycle();
    drive(1, 32'hC, 0, 0, 0, 3'b001, 0, 5'd9, 0, 1); cycle();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_ready", {31'd0, in_ready}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle(); cycle();
    check("flush_dropped", {31'd0, out_valid}, 32'd0);

    // Non-shift with immediate
    drive(1, 32'h5, 32'h0, 32'hFFFF_FFFF, 1, 3'b000, 0, 5'd4, 1, 0); cycle();
    check("ns_op", {30'd0, out_op}, 32'd3);
    check("ns_b", out_b, 32'hFFFF_FFFF);
    check("ns_n", {27'd0, out_n}, 32'h1F);

    // SRAI with reserved shamt[5]
    drive(1, 32'h5, 32'h0, 32'h0000_0420, 1, 3'b101, 1, 5'd6, 1, 0); cycle();
    check("srai_n", {27'd0, out_n}, 32'd0);
`ifdef ALU_SHIFT_ILLEGAL_CHECK_EN
    check("srai_illegal", {31'd0, out_illegal}, 32'd1);
`else
    check("srai_illegal", {31'd0, out_illegal}, 32'd0);
`endif

    // Reset mid-cycle with both entries full
    drive(1, 32'h77, 32'h1, 0, 0, 3'b001, 0, 5'd12, 0, 0); cycle();
    drive(1, 32'h88, 32'h2, 0, 0, 3'b001, 0, 5'd13, 0, 0); cycle();
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_a", out_a, 32'd0);
    check("rst_b", out_b, 32'd0);
    check("rst_rd", {27'd0, out_rd}, 32'd0);
    exp_q.delete();
    after_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    compare();
    cycle();
    check("rst2_ready", {31'd0, in_ready}, 32'd1);
    check("rst2_valid", {31'd0, out_valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [2:0] f3;
      r  = $urandom_range(0, 9);
      f3 = (r < 3) ? 3'b001 : (r < 7) ? 3'b101 : 3'($urandom);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, 1'($urandom),
            f3, 1'($urandom), 5'($urandom), $urandom_range(0, 9) < 7,
            $urandom_range(0, 31) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
